// File: rtl/control_sequencer_if.sv
// Handshake and status bundle between the instruction source and the
// control sequencer. The master drives fetch/stall controls. The slave, which
// is the sequencer, drives the IR, micro-state and status back.
interface control_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
);
   logic              run;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_in;
   logic              stall;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [3:0]        state;
   logic              busy;
   logic              done;
   logic              illegal;
   logic [CNT_W-1:0]  retired;

   modport master (
      output run, instr_valid, instr_in, stall,
      input  instr_ready, instr, state, busy, done, illegal, retired
   );

   modport slave (
      input  run, instr_valid, instr_in, stall,
      output instr_ready, instr, state, busy, done, illegal, retired
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU.
// It latches one instruction per handshake and then walks a 4-bit micro-state
// through that opcode's steps. The state encoding is fixed because the
// downstream control decoder decodes these exact values.
// When an instruction retires, the sequencer pulses done and bumps a
// wrapping counter. When the opcode is 3'b111, it pulses illegal instead.
module control_sequencer #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input logic             clock,
   input logic             resetn,
   control_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE   = 4'b0000,
      DECODE = 4'b0001,
      LOAD   = 4'b0010,
      MOVE   = 4'b0011,
      LDPC   = 4'b0100,
      BRANCH = 4'b0101,
      SUB0   = 4'b0110,
      SUB1   = 4'b0111,
      SUB2   = 4'b1000,
      ADD0   = 4'b1001,
      ADD1   = 4'b1010,
      ADD2   = 4'b1011,
      XOR0   = 4'b1100,
      XOR1   = 4'b1101,
      XOR2   = 4'b1110,
      UNUSED = 4'b1111
   } state_t;

   state_t            stateQ, stateD;
   logic [DATA_W-1:0] instrQ, instrD;
   logic              doneQ, doneD;
   logic              illegalQ, illegalD;
   logic [CNT_W-1:0]  retiredQ, retiredD;
   logic [2:0]        opcode;

   assign opcode          = instrQ[DATA_W-1 -: 3];
   assign bus.instr_ready = (stateQ == IDLE) && bus.run;
   assign bus.busy        = (stateQ != IDLE);
   assign bus.instr       = instrQ;
   assign bus.state       = stateQ;
   assign bus.done        = doneQ;
   assign bus.illegal     = illegalQ;
   assign bus.retired     = retiredQ;

   // Next-state logic: accept in IDLE, hold everything while stalled, otherwise advance one micro-step
   always_comb begin
      stateD   = stateQ;
      instrD   = instrQ;
      doneD    = 1'b0;
      illegalD = 1'b0;
      retiredD = retiredQ;
      if (stateQ == IDLE) begin
         if (bus.run && bus.instr_valid) begin
            instrD = bus.instr_in;
            stateD = DECODE;
         end
      end else if (stateQ == UNUSED) begin
         stateD = IDLE;
      end else if (!bus.stall) begin
         case (stateQ)
            DECODE: begin
               case (opcode)
                  3'b000: stateD = LOAD;
                  3'b001: stateD = MOVE;
                  3'b010: stateD = LDPC;
                  3'b011: stateD = BRANCH;
                  3'b100: stateD = SUB0;
                  3'b101: stateD = ADD0;
                  3'b110: stateD = XOR0;
                  3'b111: begin
                     stateD   = IDLE;
                     illegalD = 1'b1;
                  end
               endcase
            end
            SUB0: stateD = SUB1;
            SUB1: stateD = SUB2;
            ADD0: stateD = ADD1;
            ADD1: stateD = ADD2;
            XOR0: stateD = XOR1;
            XOR1: stateD = XOR2;
            LOAD, MOVE, LDPC, BRANCH, SUB2, ADD2, XOR2: begin
               stateD   = IDLE;
               doneD    = 1'b1;
               retiredD = retiredQ + CNT_W'(1);
            end
            default: stateD = IDLE;
         endcase
      end
   end

   // State, IR, status pulses and retire counter; reset aborts any instruction in flight
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stateQ   <= IDLE;
         instrQ   <= '0;
         doneQ    <= 1'b0;
         illegalQ <= 1'b0;
         retiredQ <= '0;
      end else begin
         stateQ   <= stateD;
         instrQ   <= instrD;
         doneQ    <= doneD;
         illegalQ <= illegalD;
         retiredQ <= retiredD;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer.
// The reference model describes each instruction as a planned list of
// micro-states. That list is derived from the opcode at accept time.
// The DUT is compared against the model every cycle, and directed scenarios
// add literal expectations.
// The retire counter is built 4 bits wide here, so wrap-around is reached in
// a handful of instructions.
module tb_control_sequencer;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   logic clock = 1'b0;
   logic resetn = 1'b0;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int               mState = 0;
   int               mPlan[$];
   logic [DATA_W-1:0] mInstr = '0;
   logic             mDone = 1'b0;
   logic             mIllegal = 1'b0;
   logic [CNT_W-1:0] mRetired = '0;

   control_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) sif ();

   control_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (sif.slave)
   );

   // Free-running clock, 10 time-unit period
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: advance on each rising edge, then compare DUT outputs just after it
   always @(posedge clock) begin
      int op;
      int base;
      if (!resetn) begin
         mState = 0;
         mPlan.delete();
         mInstr = '0;
         mDone = 1'b0;
         mIllegal = 1'b0;
         mRetired = '0;
      end else begin
         mDone = 1'b0;
         mIllegal = 1'b0;
         if (mState == 0) begin
            if (sif.run && sif.instr_valid) begin
               mInstr = sif.instr_in;
               mState = 1;
               mPlan.delete();
               op = int'(mInstr[DATA_W-1 -: 3]);
               if (op < 4) begin
                  mPlan.push_back(2 + op);
               end else if (op < 7) begin
                  base = 6 + 3 * (op - 4);
                  mPlan.push_back(base);
                  mPlan.push_back(base + 1);
                  mPlan.push_back(base + 2);
               end
            end
         end else if (!sif.stall) begin
            if (mPlan.size() > 0) begin
               mState = mPlan.pop_front();
            end else begin
               if (mState == 1) mIllegal = 1'b1;
               else begin
                  mDone = 1'b1;
                  mRetired = mRetired + 1'b1;
               end
               mState = 0;
            end
         end
      end
      #1;
      checkOutput("state",       32'(sif.state),       32'(mState));
      checkOutput("instr",       32'(sif.instr),       32'(mInstr));
      checkOutput("done",        32'(sif.done),        32'(mDone));
      checkOutput("illegal",     32'(sif.illegal),     32'(mIllegal));
      checkOutput("retired",     32'(sif.retired),     32'(mRetired));
      checkOutput("busy",        32'(sif.busy),        32'(mState != 0));
      checkOutput("instr_ready", 32'(sif.instr_ready), 32'((mState == 0) && sif.run));
   end

   // One clock of stimulus: drive on the falling edge, return just after the rising edge
   task automatic applyStimulus(input logic r, input logic v, input logic [DATA_W-1:0] ins, input logic s);
      @(negedge clock);
      sif.run = r;
      sif.instr_valid = v;
      sif.instr_in = ins;
      sif.stall = s;
      @(posedge clock);
      #2;
   endtask

   task automatic applyReset();
      @(negedge clock);
      resetn = 1'b0;
      sif.run = 1'b0;
      sif.instr_valid = 1'b0;
      sif.stall = 1'b0;
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      sif.run = 1'b0;
      sif.instr_valid = 1'b0;
      sif.instr_in = '0;
      sif.stall = 1'b0;
      applyReset();
      #1;
      checkOutput("rst_state",   32'(sif.state),   32'h0);
      checkOutput("rst_retired", 32'(sif.retired), 32'h0);
      checkOutput("rst_instr",   32'(sif.instr),   32'h0);

      $display("[TB] ADD r1,r2 latency");
      applyStimulus(1, 1, 16'hA500, 0); checkOutput("add_s1", 32'(sif.state), 32'h1);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("add_s2", 32'(sif.state), 32'h9);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("add_s3", 32'(sif.state), 32'hA);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("add_s4", 32'(sif.state), 32'hB);
      checkOutput("add_nodone", 32'(sif.done), 32'h0);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("add_s5", 32'(sif.state), 32'h0);
      checkOutput("add_done", 32'(sif.done), 32'h1);
      checkOutput("add_ret",  32'(sif.retired), 32'h1);
      checkOutput("add_ir",   32'(sif.instr), 32'hA500);

      $display("[TB] reset mid-SUB1");
      applyStimulus(1, 1, 16'h8000, 0);
      applyStimulus(1, 0, 16'h0000, 0);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("sub_s1", 32'(sif.state), 32'h7);
      @(negedge clock);
      resetn = 1'b0;
      #1;
      checkOutput("arst_state",   32'(sif.state),   32'h0);
      checkOutput("arst_retired", 32'(sif.retired), 32'h0);
      checkOutput("arst_done",    32'(sif.done),    32'h0);
      @(negedge clock);
      resetn = 1'b1;
      sif.run = 1'b1;
      sif.instr_valid = 1'b0;
      #1;
      checkOutput("arst_ready", 32'(sif.instr_ready), 32'h1);

      $display("[TB] LOAD then MOVE back-to-back");
      applyReset();
      applyStimulus(1, 1, 16'h0000, 0); checkOutput("bb_s1", 32'(sif.state), 32'h1);
      applyStimulus(1, 1, 16'h0000, 0); checkOutput("bb_s2", 32'(sif.state), 32'h2);
      applyStimulus(1, 1, 16'h2000, 0); checkOutput("bb_s3", 32'(sif.state), 32'h0);
      checkOutput("bb_done1", 32'(sif.done), 32'h1);
      checkOutput("bb_ir1",   32'(sif.instr), 32'h0000);
      applyStimulus(1, 1, 16'h2000, 0); checkOutput("bb_s4", 32'(sif.state), 32'h1);
      checkOutput("bb_ir2", 32'(sif.instr), 32'h2000);
      applyStimulus(1, 1, 16'h4000, 0); checkOutput("bb_s5", 32'(sif.state), 32'h3);
      checkOutput("bb_ir_hold", 32'(sif.instr), 32'h2000);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("bb_s6", 32'(sif.state), 32'h0);
      checkOutput("bb_done2", 32'(sif.done), 32'h1);
      checkOutput("bb_ret",   32'(sif.retired), 32'h2);

      $display("[TB] XOR with stall in XOR1");
      applyReset();
      applyStimulus(1, 1, 16'hC000, 0);
      applyStimulus(0, 0, 16'h0000, 0);
      applyStimulus(0, 0, 16'h0000, 0); checkOutput("xor_s3", 32'(sif.state), 32'hD);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 16'h0000, 1);
         checkOutput("xor_stall", 32'(sif.state), 32'hD);
         checkOutput("xor_stall_done", 32'(sif.done), 32'h0);
      end
      applyStimulus(0, 0, 16'h0000, 0); checkOutput("xor_s7", 32'(sif.state), 32'hE);
      applyStimulus(0, 0, 16'h0000, 0); checkOutput("xor_s8", 32'(sif.state), 32'h0);
      checkOutput("xor_done", 32'(sif.done), 32'h1);

      $display("[TB] illegal opcode");
      applyReset();
      applyStimulus(1, 1, 16'hE000, 0); checkOutput("ill_s1", 32'(sif.state), 32'h1);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("ill_s2", 32'(sif.state), 32'h0);
      checkOutput("ill_pulse", 32'(sif.illegal), 32'h1);
      checkOutput("ill_nodone", 32'(sif.done), 32'h0);
      checkOutput("ill_ret", 32'(sif.retired), 32'h0);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("ill_clear", 32'(sif.illegal), 32'h0);

      $display("[TB] retire counter wrap");
      applyReset();
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1, 1, 16'h4000, 0);
         applyStimulus(1, 0, 16'h0000, 0);
         applyStimulus(1, 0, 16'h0000, 0);
      end
      checkOutput("wrap_pre", 32'(sif.retired), 32'hF);
      applyStimulus(1, 1, 16'h6000, 0);
      applyStimulus(1, 0, 16'h0000, 0); checkOutput("br_s2", 32'(sif.state), 32'h5);
      applyStimulus(1, 0, 16'h0000, 0);
      checkOutput("wrap_done", 32'(sif.done), 32'h1);
      checkOutput("wrap_ret",  32'(sif.retired), 32'h0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         resetn = ($urandom_range(0, 249) != 0);
         sif.run = ($urandom_range(0, 3) != 0);
         sif.instr_valid = $urandom_range(0, 1) != 0;
         sif.instr_in = DATA_W'($urandom);
         sif.stall = ($urandom_range(0, 3) == 0);
      end
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
